// File: rtl/fpu_bcd80_to_uint64.sv
// Sequential 8087 packed-BCD (sign + 18 digits) to 64-bit unsigned magnitude decoder.
// Consumes DIGITS_PER_CYCLE digits per clock, most significant digit first.
module fpu_bcd80_to_uint64 #(
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [79:0] bcd_i,
  output logic [63:0] uint_o,
  output logic        sign_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        invalid_o
);

  localparam int NumCycles = 18 / DIGITS_PER_CYCLE;
  localparam int ShiftBits = 4 * DIGITS_PER_CYCLE;
  localparam logic [4:0] LastCnt = 5'(NumCycles - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t      state_q, state_d;
  logic [71:0] shift_q, shift_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        bad_q, bad_d;
  logic [63:0] uint_q, uint_d;
  logic        signOut_q, signOut_d;
  logic        invalid_q, invalid_d;

  logic [63:0] accStep;
  logic        badStep;
  logic [3:0]  nibble;

  // Bits [78:72] of the operand carry no information for the conversion.
  logic unused_ignoredBits;
  assign unused_ignoredBits = ^bcd_i[78:72];

  // acc*10 is built from two shifts so no multiplier is inferred.
  always_comb begin
    accStep = acc_q;
    badStep = bad_q;
    nibble  = 4'd0;
    for (int i = 0; i < DIGITS_PER_CYCLE; i++) begin
      nibble  = shift_q[71 - 4*i -: 4];
      accStep = (accStep << 3) + (accStep << 1) + {60'd0, nibble};
      badStep = badStep | (nibble > 4'd9);
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    bad_d     = bad_q;
    uint_d    = uint_q;
    signOut_d = signOut_q;
    invalid_d = invalid_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = CONVERT;
          shift_d = bcd_i[71:0];
          sign_d  = bcd_i[79];
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          bad_d   = 1'b0;
        end
      end
      CONVERT: begin
        acc_d   = accStep;
        bad_d   = badStep;
        shift_d = shift_q << ShiftBits;
        cnt_d   = cnt_q + 5'd1;
        // Result registers load on the edge that enters DONE and then hold.
        if (cnt_q == LastCnt) begin
          state_d   = DONE;
          uint_d    = badStep ? 64'd0 : accStep;
          signOut_d = sign_q;
          invalid_d = badStep;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shift_q   <= 72'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 5'd0;
      sign_q    <= 1'b0;
      bad_q     <= 1'b0;
      uint_q    <= 64'd0;
      signOut_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      bad_q     <= bad_d;
      uint_q    <= uint_d;
      signOut_q <= signOut_d;
      invalid_q <= invalid_d;
    end
  end

  assign uint_o    = uint_q;
  assign sign_o    = signOut_q;
  assign invalid_o = invalid_q;
  assign done_o    = (state_q == DONE);
  assign busy_o    = (state_q != IDLE);

endmodule
